// File: rtl/wb_tpm_buf_bridge.sv
// wb_tpm_buf_bridge: Wishbone responder giving the M4 word access to the shared
// TPM command/response buffer RAM (via a request/grant port) plus control,
// status and interrupt registers for the exec/abort/complete handshake.
// Optional feature macro: TWPM_WB_GNT_TIMEOUT_EN (bounded wait for ram_gnt).
module wb_tpm_buf_bridge #(
   parameter int unsigned RAM_AW      = 9,
   parameter int unsigned GNT_TIMEOUT = 64,
   parameter logic [31:0] ID_VALUE    = 32'h54504D32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [16:0]       WBs_ADR,
   input  logic              WBs_CYC,
   input  logic              WBs_STB,
   input  logic              WBs_WE,
   input  logic              WBs_RD,
   input  logic [3:0]        WBs_BYTE_STB,
   input  logic [31:0]       WBs_WR_DAT,
   output logic [31:0]       WBs_RD_DAT,
   output logic              WBs_ACK,
   output logic              ram_req,
   input  logic              ram_gnt,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic [3:0]        ram_be,
   output logic              ram_we,
   input  logic [31:0]       ram_rdata,
   input  logic              exec_i,
   input  logic              abort_i,
   output logic              complete_o,
   output logic              irq_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDW, S_ACK} state_t;

   localparam logic [14:0] A_ID     = 15'h200;
   localparam logic [14:0] A_STATUS = 15'h201;
   localparam logic [14:0] A_CTRL   = 15'h202;
   localparam logic [14:0] A_INTEN  = 15'h203;

   state_t      state_q, state_d;
   logic [31:0] rd_dat_q, rd_dat_d;
   logic        exec_s1_q, exec_s2_q, exec_p_q;
   logic        abort_s1_q, abort_s2_q, abort_p_q;
   logic        exec_evt_q, exec_evt_d;
   logic        abort_evt_q, abort_evt_d;
   logic [1:0]  int_en_q, int_en_d;
   logic        complete_q, complete_d;
   logic        irq_q, irq_d;
   logic        gnt_err;

   logic        stb;
   logic        is_ram;
   logic        reg_wr;
   logic [31:0] reg_rdata;
   logic        st_wr, ctrl_wr, inten_wr;
   logic        exec_rise, abort_rise;

`ifdef TWPM_WB_GNT_TIMEOUT_EN
   localparam int unsigned CW = $clog2(GNT_TIMEOUT + 1);
   logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_hit;
   logic          gnt_err_q, gnt_err_d;
   assign gnt_err = gnt_err_q;
`else
   assign gnt_err = 1'b0;
`endif

   logic unused_ok;
   assign unused_ok = ^{WBs_RD, WBs_ADR[1:0], 32'(GNT_TIMEOUT)};

   assign stb        = WBs_CYC & WBs_STB;
   assign is_ram     = (WBs_ADR[16:11] == '0);
   assign ram_req    = (state_q == S_REQ) & stb;
   assign ram_we     = ram_req & WBs_WE;
   assign ram_addr   = WBs_ADR[RAM_AW+1:2];
   assign ram_wdata  = WBs_WR_DAT;
   assign ram_be     = WBs_BYTE_STB;
   assign WBs_ACK    = (state_q == S_ACK);
   assign WBs_RD_DAT = rd_dat_q;
   assign complete_o = complete_q;
   assign irq_o      = irq_q;

   assign exec_rise  = exec_s2_q & ~exec_p_q;
   assign abort_rise = abort_s2_q & ~abort_p_q;

   // Register read multiplexer; unmapped addresses read as zero.
   always_comb begin
      reg_rdata = '0;
      case (WBs_ADR[16:2])
         A_ID:     reg_rdata = ID_VALUE;
         A_STATUS: reg_rdata = {27'd0, gnt_err, abort_evt_q, exec_evt_q, abort_s2_q, exec_s2_q};
         A_CTRL:   reg_rdata = {31'd0, complete_q};
         A_INTEN:  reg_rdata = {28'd0, int_en_q, 2'b00};
         default:  reg_rdata = '0;
      endcase
   end

   // Bus FSM next state, read-data capture and register-write strobe.
   always_comb begin
      state_d  = state_q;
      rd_dat_d = rd_dat_q;
      reg_wr   = 1'b0;
`ifdef TWPM_WB_GNT_TIMEOUT_EN
      tmo_hit   = 1'b0;
      tmo_cnt_d = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (stb) begin
               if (is_ram) begin
                  state_d = S_REQ;
               end else begin
                  state_d = S_ACK;
                  if (WBs_WE) reg_wr = WBs_BYTE_STB[0];
                  else        rd_dat_d = reg_rdata;
               end
            end
         end
         S_REQ: begin
            if (!stb) begin
               state_d = S_IDLE;
            end else if (ram_gnt) begin
               state_d = WBs_WE ? S_ACK : S_RDW;
`ifdef TWPM_WB_GNT_TIMEOUT_EN
            end else if (tmo_cnt_q == CW'(GNT_TIMEOUT - 1)) begin
               // grant is checked first, so a grant on the timeout edge still completes
               state_d  = S_ACK;
               rd_dat_d = '1;
               tmo_hit  = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
            end
         end
         S_RDW: begin
            rd_dat_d = ram_rdata;
            state_d  = S_ACK;
         end
         S_ACK: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control/status register next state: sticky events, W1C, complete handshake, irq.
   always_comb begin
      st_wr    = reg_wr && (WBs_ADR[16:2] == A_STATUS);
      ctrl_wr  = reg_wr && (WBs_ADR[16:2] == A_CTRL);
      inten_wr = reg_wr && (WBs_ADR[16:2] == A_INTEN);

      exec_evt_d  = exec_rise  | (exec_evt_q  & ~(st_wr & WBs_WR_DAT[2]));
      abort_evt_d = abort_rise | (abort_evt_q & ~(st_wr & WBs_WR_DAT[3]));
      int_en_d    = inten_wr ? WBs_WR_DAT[3:2] : int_en_q;

      complete_d = complete_q;
      if (complete_q && !exec_s2_q) complete_d = 1'b0;
      else if (ctrl_wr)             complete_d = WBs_WR_DAT[0];

      irq_d = |({abort_evt_q, exec_evt_q} & int_en_q);
`ifdef TWPM_WB_GNT_TIMEOUT_EN
      gnt_err_d = tmo_hit | (gnt_err_q & ~(st_wr & WBs_WR_DAT[4]));
`endif
   end

   // State registers and input synchronizers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         rd_dat_q    <= '0;
         exec_s1_q   <= 1'b0;
         exec_s2_q   <= 1'b0;
         exec_p_q    <= 1'b0;
         abort_s1_q  <= 1'b0;
         abort_s2_q  <= 1'b0;
         abort_p_q   <= 1'b0;
         exec_evt_q  <= 1'b0;
         abort_evt_q <= 1'b0;
         int_en_q    <= '0;
         complete_q  <= 1'b0;
         irq_q       <= 1'b0;
`ifdef TWPM_WB_GNT_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         gnt_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rd_dat_q    <= rd_dat_d;
         exec_s1_q   <= exec_i;
         exec_s2_q   <= exec_s1_q;
         exec_p_q    <= exec_s2_q;
         abort_s1_q  <= abort_i;
         abort_s2_q  <= abort_s1_q;
         abort_p_q   <= abort_s2_q;
         exec_evt_q  <= exec_evt_d;
         abort_evt_q <= abort_evt_d;
         int_en_q    <= int_en_d;
         complete_q  <= complete_d;
         irq_q       <= irq_d;
`ifdef TWPM_WB_GNT_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
         gnt_err_q   <= gnt_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_wb_tpm_buf_bridge.sv
// Bench for wb_tpm_buf_bridge: table of single Wishbone transfers with
// hand-computed data and latency, plus directed multi-cycle sequences.
module tb_wb_tpm_buf_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [16:0] WBs_ADR = '0;
   logic        WBs_CYC = 1'b0;
   logic        WBs_STB = 1'b0;
   logic        WBs_WE = 1'b0;
   logic        WBs_RD = 1'b0;
   logic [3:0]  WBs_BYTE_STB = '0;
   logic [31:0] WBs_WR_DAT = '0;
   logic [31:0] WBs_RD_DAT;
   logic        WBs_ACK;
   logic        ram_req;
   logic        ram_gnt;
   logic [8:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_be;
   logic        ram_we;
   logic [31:0] ram_rdata = '0;
   logic        exec_i = 1'b0;
   logic        abort_i = 1'b0;
   logic        complete_o;
   logic        irq_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wb_tpm_buf_bridge #(.RAM_AW(9), .GNT_TIMEOUT(64), .ID_VALUE(32'h54504D32)) dut (
      .clk_i(clk), .rst_i(rst),
      .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_STB(WBs_STB), .WBs_WE(WBs_WE),
      .WBs_RD(WBs_RD), .WBs_BYTE_STB(WBs_BYTE_STB), .WBs_WR_DAT(WBs_WR_DAT),
      .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
      .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_be(ram_be), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .exec_i(exec_i), .abort_i(abort_i), .complete_o(complete_o), .irq_o(irq_o)
   );

   // RAM model: grant after gdly request cycles, registered read data
   logic [31:0] mem [0:511];
   int          gdly = 0;
   int          req_cnt = 0;
   int          acc_cnt = 0;
   logic [8:0]  cap_addr = '0;
   logic [3:0]  cap_be = '0;
   logic        cap_we = 1'b0;
   logic [31:0] cap_wdata = '0;

   assign ram_gnt = (req_cnt >= gdly);

   initial for (int i = 0; i < 512; i++) mem[i] = '0;

   always @(posedge clk) begin
      req_cnt <= ram_req ? req_cnt + 1 : 0;
      if (ram_req && ram_gnt) begin
         for (int b = 0; b < 4; b++)
            if (ram_we && ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= mem[ram_addr];
         acc_cnt   <= acc_cnt + 1;
         cap_addr  <= ram_addr;
         cap_be    <= ram_be;
         cap_we    <= ram_we;
         cap_wdata <= ram_wdata;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One transfer; lat = number of edges from the STB sample edge to the ACK edge, -1 on timeout
   task automatic xfer(input logic [16:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] d, output logic [31:0] rd, output int lat);
      @(posedge clk); #1;
      WBs_ADR = a; WBs_WE = we; WBs_RD = ~we; WBs_BYTE_STB = be; WBs_WR_DAT = d;
      WBs_CYC = 1'b1; WBs_STB = 1'b1;
      @(posedge clk);
      lat = -1;
      rd  = '0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (WBs_ACK) begin
            lat = k;
            rd  = WBs_RD_DAT;
            break;
         end
      end
      @(posedge clk); #1;
      WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_WE = 1'b0; WBs_RD = 1'b0;
   endtask

   typedef struct {
      logic [16:0] adr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdat;
      int          gd;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t vecs[16];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          lat;
      int          acks;
      int          acc0;

      vecs[0]  = '{17'h00800, 1'b0, 4'hF, 32'h0,        0, 32'h54504D32, 1};
      vecs[1]  = '{17'h00010, 1'b1, 4'h5, 32'hAABBCCDD, 0, 32'h0,        2};
      vecs[2]  = '{17'h00010, 1'b0, 4'hF, 32'h0,        0, 32'h00BB00DD, 3};
      vecs[3]  = '{17'h007FC, 1'b1, 4'hF, 32'h12345678, 2, 32'h0,        4};
      vecs[4]  = '{17'h007FC, 1'b0, 4'hF, 32'h0,        5, 32'h12345678, 8};
      vecs[5]  = '{17'h00013, 1'b0, 4'hF, 32'h0,        0, 32'h00BB00DD, 3};
      vecs[6]  = '{17'h00804, 1'b0, 4'hF, 32'h0,        0, 32'h0,        1};
      vecs[7]  = '{17'h0080C, 1'b1, 4'hE, 32'hFFFFFFFF, 0, 32'h0,        1};
      vecs[8]  = '{17'h0080C, 1'b0, 4'hF, 32'h0,        0, 32'h0,        1};
      vecs[9]  = '{17'h0080C, 1'b1, 4'h1, 32'h0000000C, 0, 32'h0,        1};
      vecs[10] = '{17'h0080C, 1'b0, 4'hF, 32'h0,        0, 32'h0000000C, 1};
      vecs[11] = '{17'h00900, 1'b1, 4'hF, 32'hFFFFFFFF, 0, 32'h0,        1};
      vecs[12] = '{17'h00900, 1'b0, 4'hF, 32'h0,        0, 32'h0,        1};
      vecs[13] = '{17'h00808, 1'b0, 4'hF, 32'h0,        0, 32'h0,        1};
      vecs[14] = '{17'h00800, 1'b1, 4'hF, 32'h0,        0, 32'h0,        1};
      vecs[15] = '{17'h00800, 1'b0, 4'hF, 32'h0,        0, 32'h54504D32, 1};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack",      32'(WBs_ACK),    32'h0);
      check("rst_rddat",    WBs_RD_DAT,      32'h0);
      check("rst_ram_req",  32'(ram_req),    32'h0);
      check("rst_ram_we",   32'(ram_we),     32'h0);
      check("rst_complete", 32'(complete_o), 32'h0);
      check("rst_irq",      32'(irq_o),      32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // table-driven transfers
      for (int i = 0; i < 16; i++) begin
         gdly = vecs[i].gd;
         xfer(vecs[i].adr, vecs[i].we, vecs[i].be, vecs[i].wdat, rd, lat);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         if (!vecs[i].we) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      end
      gdly = 0;

      // RAM port signals during a granted write
      xfer(17'h00020, 1'b1, 4'hA, 32'h11223344, rd, lat);
      check("ramw_addr",  32'(cap_addr), 32'h8);
      check("ramw_be",    32'(cap_be),   32'hA);
      check("ramw_we",    32'(cap_we),   32'h1);
      check("ramw_wdata", cap_wdata,     32'h11223344);
      xfer(17'h00020, 1'b0, 4'hF, 32'h0, rd, lat);
      check("ramw_readback", rd, 32'h11003300);

      // STB dropped while waiting for a grant
      gdly = 1000;
      acc0 = acc_cnt;
      @(posedge clk); #1;
      WBs_ADR = 17'h00010; WBs_WE = 1'b0; WBs_RD = 1'b1; WBs_BYTE_STB = 4'hF;
      WBs_CYC = 1'b1; WBs_STB = 1'b1;
      repeat (3) @(negedge clk);
      check("drop_req_up", 32'(ram_req), 32'h1);
      @(posedge clk); #1;
      WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_RD = 1'b0;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (WBs_ACK) acks++;
      end
      check("drop_req_down", 32'(ram_req), 32'h0);
      check("drop_no_ack",   32'(acks),    32'h0);
      check("drop_no_acc",   32'(acc_cnt - acc0), 32'h0);
      gdly = 0;
      xfer(17'h00800, 1'b0, 4'hF, 32'h0, rd, lat);
      check("drop_idle_lat", 32'(lat), 32'h1);

      // exec event, interrupt, W1C, complete handshake
      xfer(17'h0080C, 1'b1, 4'h1, 32'h4, rd, lat);
      @(posedge clk); #1;
      exec_i = 1'b1;
      repeat (4) @(negedge clk);
      check("irq_not_yet", 32'(irq_o), 32'h0);
      @(negedge clk);
      check("irq_exec", 32'(irq_o), 32'h1);
      xfer(17'h00804, 1'b0, 4'hF, 32'h0, rd, lat);
      check("status_exec", rd, 32'h5);
      xfer(17'h00804, 1'b1, 4'h1, 32'h4, rd, lat);
      @(negedge clk);
      check("irq_w1c", 32'(irq_o), 32'h0);
      xfer(17'h00804, 1'b0, 4'hF, 32'h0, rd, lat);
      check("status_w1c", rd, 32'h1);
      xfer(17'h00808, 1'b1, 4'h1, 32'h1, rd, lat);
      @(negedge clk);
      check("complete_set", 32'(complete_o), 32'h1);
      xfer(17'h00808, 1'b0, 4'hF, 32'h0, rd, lat);
      check("ctrl_read", rd, 32'h1);
      @(posedge clk); #1;
      exec_i = 1'b0;
      repeat (3) @(negedge clk);
      check("complete_hold", 32'(complete_o), 32'h1);
      @(negedge clk);
      check("complete_auto_clr", 32'(complete_o), 32'h0);

      // abort event is masked with INT_EN=0100, unmasked with 1100
      @(posedge clk); #1;
      abort_i = 1'b1;
      repeat (6) @(negedge clk);
      check("irq_abort_masked", 32'(irq_o), 32'h0);
      xfer(17'h00804, 1'b0, 4'hF, 32'h0, rd, lat);
      check("status_abort", rd, 32'hA);
      xfer(17'h0080C, 1'b1, 4'h1, 32'hC, rd, lat);
      @(negedge clk);
      check("irq_abort_en", 32'(irq_o), 32'h1);
      @(posedge clk); #1;
      abort_i = 1'b0;
      repeat (4) @(posedge clk);

      // reset while in RDW
      xfer(17'h00800, 1'b0, 4'hF, 32'h0, rd, lat);
      @(posedge clk); #1;
      WBs_ADR = 17'h00010; WBs_WE = 1'b0; WBs_RD = 1'b1; WBs_BYTE_STB = 4'hF;
      WBs_CYC = 1'b1; WBs_STB = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_RD = 1'b0;
      @(negedge clk);
      check("rdw_rst_ack",   32'(WBs_ACK), 32'h0);
      check("rdw_rst_req",   32'(ram_req), 32'h0);
      check("rdw_rst_rddat", WBs_RD_DAT,   32'h0);
      check("rdw_rst_irq",   32'(irq_o),   32'h0);
      xfer(17'h0080C, 1'b0, 4'hF, 32'h0, rd, lat);
      check("rdw_rst_inten", rd, 32'h0);
      xfer(17'h00804, 1'b0, 4'hF, 32'h0, rd, lat);
      check("rdw_rst_status", rd, 32'h0);

`ifdef TWPM_WB_GNT_TIMEOUT_EN
      // grant never arrives: timeout completes the access with all-ones data
      gdly = 100000;
      xfer(17'h00010, 1'b0, 4'hF, 32'h0, rd, lat);
      check("tmo_lat", 32'(lat), 32'd65);
      check("tmo_rd",  rd,       32'hFFFFFFFF);
      gdly = 0;
      xfer(17'h00804, 1'b0, 4'hF, 32'h0, rd, lat);
      check("tmo_status", rd, 32'h10);
      xfer(17'h00804, 1'b1, 4'h1, 32'h10, rd, lat);
      xfer(17'h00804, 1'b0, 4'hF, 32'h0, rd, lat);
      check("tmo_w1c", rd, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wb_tpm_buf_bridge.md
Name: wb_tpm_buf_bridge

Overview:
- Wishbone responder on the M4 side of the TwPM fabric. It answers the qlal4s3b AHB-to-FPGA bridge master (WBs_*).
- Gives firmware word access to the shared TPM command/response buffer RAM, which the LPC-side register block writes. Firmware reads commands from it and writes responses back.
- Replaces the temporary exec/complete/abort pins with memory-mapped control/status registers and an interrupt.
- RAM access goes through a request/grant port, because the LPC side also uses the same RAM.

Parameters:
- RAM_AW, 9, RAM word-address width (512x32 buffer)
- GNT_TIMEOUT, 64, maximum cycles to wait for ram_gnt (used only with the optional feature)
- ID_VALUE, 32'h54504D32, value returned by the ID register

Ports:
- clk_i  in  1  Wishbone clock (WB_CLK)
- rst_i  in  1  synchronous active-high reset (WB_RST_FPGA)
- WBs_ADR  in  17  byte address
- WBs_CYC  in  1  cycle select
- WBs_STB  in  1  strobe
- WBs_WE  in  1  write enable
- WBs_RD  in  1  read enable (informational; WE decides the direction)
- WBs_BYTE_STB  in  4  byte enables
- WBs_WR_DAT  in  32  write data
- WBs_RD_DAT  out  32  read data, valid while WBs_ACK=1
- WBs_ACK  out  1  one-cycle acknowledge
- ram_req  out  1  RAM port request
- ram_gnt  in  1  RAM port grant; access takes place on the edge where ram_req&ram_gnt
- ram_addr  out  RAM_AW  word address, equal to WBs_ADR[RAM_AW+1:2]
- ram_wdata  out  32  write data
- ram_be  out  4  byte enables, equal to WBs_BYTE_STB
- ram_we  out  1  write qualifier during a request
- ram_rdata  in  32  read data, valid one cycle after the granted edge
- exec_i  in  1  exec level from the LCLK domain (asynchronous)
- abort_i  in  1  abort level from the LCLK domain (asynchronous)
- complete_o  out  1  complete level toward the LPC side
- irq_o  out  1  level interrupt to the M4

Behaviour:
- Reset values:
  - WBs_ACK=0, WBs_RD_DAT=0, ram_req=0, ram_we=0, complete_o=0, irq_o=0.
  - All registers and synchronizers are 0; the FSM is in IDLE.
- exec_i and abort_i each pass through a 2-flop synchronizer before any use. Rising-edge detectors run on the synchronized signals.
- Address map, word aligned; WBs_ADR[1:0] is ignored:
  - 0x0000-0x07FF: buffer RAM.
  - 0x0800 ID (RO): returns ID_VALUE.
  - 0x0804 STATUS:
    - bit0 exec (synchronized level, RO).
    - bit1 abort (synchronized level, RO).
    - bit2 exec_evt: sticky, set on exec rising edge, write-1-to-clear.
    - bit3 abort_evt: sticky, set on abort rising edge, write-1-to-clear.
    - bit4 gnt_err: W1C; exists only with the optional feature.
  - 0x0808 CTRL: bit0 complete. Writing 1 sets complete_o. Writing 0 clears it.
  - 0x080C INT_EN: bits[3:2] enable exec_evt and abort_evt.
  - Any other address: ACKed, read returns 0, write is ignored.
- Register writes take effect only when WBs_BYTE_STB[0]=1.
- irq_o = |(STATUS[3:2] & INT_EN[3:2]), registered (one cycle after the event bit sets).
- complete_o auto-clear: cleared on the cycle after synchronized exec is seen low while complete_o=1 (4-phase handshake). Auto-clear takes priority over a CTRL write in the same cycle.
- Simultaneous W1C write and a new event on the same bit: the set wins.
- FSM:
  - IDLE:
    - When CYC&STB and ACK=0: a register access goes to ACK. A RAM access goes to REQ.
  - REQ:
    - ram_req=1; ram_we=WBs_WE; address, data and enables are driven from the WBs inputs.
    - On an edge with ram_gnt=1: a write goes to ACK; a read goes to RDW.
  - RDW:
    - Capture ram_rdata into WBs_RD_DAT, then go to ACK.
  - ACK:
    - WBs_ACK=1 for exactly one cycle, then IDLE.
    - The master must drop STB in the cycle after ACK. IDLE does not restart while ACK is high.
- Latency counted from the STB sample edge:
  - Register access: ACK at +1.
  - RAM write: ACK at +2 with immediate grant.
  - RAM read: ACK at +3 with immediate grant.
  - Each cycle ram_gnt stays low adds one cycle.
- STB or CYC dropped while in REQ: return to IDLE with no RAM access and no ACK.
- rst_i asserted in any state: IDLE on the next edge; ram_req and ACK drop on that same edge.
- WBs_RD_DAT holds its last value outside ACK.

Optional Feature:
- Macro: TWPM_WB_GNT_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ. On reaching GNT_TIMEOUT cycles without a grant, the FSM leaves REQ for ACK with WBs_RD_DAT=32'hFFFFFFFF. Writes are dropped.
  - STATUS bit4 gnt_err is set.
  - A grant on the same edge as the timeout wins: the access completes normally.
- Undefined:
  - REQ waits indefinitely for ram_gnt.
  - STATUS bit4 reads 0; the counter is absent.

Test Plan:
- Read 0x0800 -> ACK one cycle after STB, WBs_RD_DAT=32'h54504D32.
- Write 0x0010 data 32'hAABBCCDD with BYTE_STB=4'b0101 and ram_gnt tied high -> ram_req=1 with ram_addr=4, ram_be=4'b0101, ram_we=1; ACK at +2. Read back with ram_rdata model -> 32'h00BB00DD at +3.
- Hold ram_gnt low 5 cycles on a read -> ACK at +8. Drop STB during REQ on a second read -> no ACK, ram_req falls, FSM in IDLE.
- INT_EN=4'b0100, raise exec_i -> STATUS=0x5 and irq_o=1 within 4 cycles. W1C 0x4 -> irq_o=0. Write CTRL=1 -> complete_o=1. Lower exec_i -> complete_o=0 within 4 cycles.
- Assert rst_i in RDW -> next cycle ACK=0, ram_req=0, all registers 0.
- With TWPM_WB_GNT_TIMEOUT_EN, GNT_TIMEOUT=64 and ram_gnt held low -> ACK 65 cycles after STB, data 32'hFFFFFFFF, STATUS bit4=1.
